// File: rtl/multiword_add_seq.sv
// Multiword add sequencer: streams operand words through one narrow external
// adder, chaining its carry between words and registering each sum word.
module multiword_add_seq #(
   parameter int DATA_WIDTH = 4,
   parameter int MAX_WORDS  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ci_init,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_last,
   input  logic                  in_vld,
   output logic                  in_rd,
   output logic [DATA_WIDTH-1:0] adder_a,
   output logic [DATA_WIDTH-1:0] adder_b,
   output logic                  adder_ci,
   input  logic [DATA_WIDTH-1:0] adder_s,
   input  logic                  adder_co,
   output logic [DATA_WIDTH-1:0] out_s,
   output logic                  out_co,
   output logic                  out_last,
   output logic                  out_err,
   output logic                  out_vld,
   input  logic                  out_rd
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic {
      FIRST = 1'b0,
      CHAIN = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            carry_reg;
   logic [CW-1:0]   word_cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            accept;
   logic            overflow;
   logic            fin;

   assign in_rd    = !out_vld | out_rd;
   assign accept   = in_vld & in_rd;
   assign adder_a  = in_a;
   assign adder_b  = in_b;
   assign adder_ci = (state == FIRST) ? ci_init : carry_reg;

   // The current word is the MAX_WORDS-th of its operation.
   assign overflow = (word_cnt == CW'(MAX_WORDS - 1));
   assign fin      = in_last | overflow;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = word_cnt;
      if (accept) begin
         if (fin) begin
            state_nxt = FIRST;
            cnt_nxt   = '0;
         end else begin
            state_nxt = CHAIN;
            cnt_nxt   = word_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FIRST;
         carry_reg <= 1'b0;
         word_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         word_cnt <= cnt_nxt;
         if (accept) begin
            carry_reg <= adder_co;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_s    <= '0;
         out_co   <= 1'b0;
         out_last <= 1'b0;
         out_err  <= 1'b0;
      end else if (accept) begin
         out_vld  <= 1'b1;
         out_s    <= adder_s;
         out_last <= fin;
         out_co   <= fin ? adder_co : 1'b0;
         out_err  <= overflow & !in_last;
      end else if (out_rd) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq with a behavioural 4-bit adder attached.
// Directed vector table plus hand sequences for multi-cycle corners.
module tb_multiword_add_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       ci_init;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_last;
   logic       in_vld;
   logic       in_rd;
   logic [3:0] adder_a;
   logic [3:0] adder_b;
   logic       adder_ci;
   logic [3:0] adder_s;
   logic       adder_co;
   logic [3:0] out_s;
   logic       out_co;
   logic       out_last;
   logic       out_err;
   logic       out_vld;
   logic       out_rd;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   assign {adder_co, adder_s} = {1'b0, adder_a} + {1'b0, adder_b}
                              + {4'b0, adder_ci};

   multiword_add_seq #(.DATA_WIDTH(4), .MAX_WORDS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .ci_init  (ci_init),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_last  (in_last),
      .in_vld   (in_vld),
      .in_rd    (in_rd),
      .adder_a  (adder_a),
      .adder_b  (adder_b),
      .adder_ci (adder_ci),
      .adder_s  (adder_s),
      .adder_co (adder_co),
      .out_s    (out_s),
      .out_co   (out_co),
      .out_last (out_last),
      .out_err  (out_err),
      .out_vld  (out_vld),
      .out_rd   (out_rd)
   );

   typedef struct {
      logic       ci;
      logic [3:0] a;
      logic [3:0] b;
      logic       last;
      logic [3:0] s;
      logic       co;
      logic       lst;
      logic       err;
   } vec_t;

   vec_t vt[10];

   function automatic logic [7:0] obs();
      return {out_vld, out_s, out_co, out_last, out_err};
   endfunction

   function automatic logic [7:0] ex(input logic [3:0] s, input logic co,
                                     input logic lst, input logic err);
      return {1'b1, s, co, lst, err};
   endfunction

   task automatic chk(input string n, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h", n, got, exp);
   endtask

   task automatic step(input logic ci, input logic [3:0] a,
                       input logic [3:0] b, input logic last);
      ci_init = ci;
      in_a    = a;
      in_b    = b;
      in_last = last;
      in_vld  = 1'b1;
      @(posedge clk);
      #1;
      in_vld  = 1'b0;
   endtask

   initial begin
      vt[0] = '{1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0};
      vt[2] = '{1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[3] = '{1'b0, 4'h8, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
      vt[4] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
      vt[5] = '{1'b1, 4'h7, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b0, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
      vt[7] = '{1'b0, 4'hA, 4'hA, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
      vt[8] = '{1'b0, 4'h5, 4'h5, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      vt[9] = '{1'b1, 4'h9, 4'h6, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; ci_init = 0; in_a = 0; in_b = 0;
      in_last = 0; in_vld = 0; out_rd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", {out_vld, out_s, out_co, out_last, out_err}, 8'h00);
      chk("reset_in_rd", {7'b0, in_rd}, 8'h01);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step(vt[i].ci, vt[i].a, vt[i].b, vt[i].last);
         chk($sformatf("vec%0d", i), obs(),
             ex(vt[i].s, vt[i].co, vt[i].lst, vt[i].err));
      end

      // Overflow: nine words with no last.
      for (int i = 1; i <= 9; i++) begin
         step(1'b1, 4'hF, 4'h0, 1'b0);
         if (i < 8)
            chk($sformatf("ovf_w%0d", i), obs(), ex(4'h0, 0, 0, 0));
         else if (i == 8)
            chk("ovf_w8", obs(), ex(4'h0, 1, 1, 1));
         else
            chk("ovf_w9", obs(), ex(4'h0, 0, 0, 0));
      end
      step(1'b0, 4'h0, 4'h0, 1'b1);
      chk("ovf_w10_chain", obs(), ex(4'h1, 0, 1, 0));

      // Exactly MAX_WORDS with last on the final word is legal.
      for (int i = 1; i <= 7; i++) step(1'b1, 4'hF, 4'h0, 1'b0);
      step(1'b0, 4'hF, 4'h0, 1'b1);
      chk("max_last", obs(), ex(4'h0, 1, 1, 0));
      step(1'b0, 4'hF, 4'h0, 1'b1);
      chk("no_leak", obs(), ex(4'hF, 0, 1, 0));

      // Backpressure on a 3-word op.
      step(1'b0, 4'hF, 4'h1, 1'b0);
      chk("bp_w1", obs(), ex(4'h0, 0, 0, 0));
      out_rd = 1'b0;
      ci_init = 1'b1; in_a = 4'h1; in_b = 4'h0; in_last = 0; in_vld = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d", i),
             {in_rd, out_vld, out_s, out_last, out_err},
             {1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
      end
      out_rd = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_w2", obs(), ex(4'h2, 0, 0, 0));
      step(1'b1, 4'h3, 4'h3, 1'b1);
      chk("bp_w3", obs(), ex(4'h6, 0, 1, 0));
      @(posedge clk);
      #1;
      chk("drain", {7'b0, out_vld}, 8'h00);

      // Reset mid-operation.
      step(1'b0, 4'hF, 4'h1, 1'b0);
      chk("rst_w1", obs(), ex(4'h0, 0, 0, 0));
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {7'b0, out_vld}, 8'h00);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, 4'h0, 4'h0, 1'b0);
         if (i == 1) chk("rst_ci", obs(), ex(4'h0, 0, 0, 0));
         if (i == 7) chk("rst_cnt7", obs(), ex(4'h0, 0, 0, 0));
      end
      step(1'b0, 4'h0, 4'h0, 1'b1);
      chk("rst_cnt8", obs(), ex(4'h0, 0, 1, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
